// File: rtl/lc3_memaccess_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_memaccess_ctrl
//  Function : LC3 MemAccess-stage sequencer. Runs one LD/LDI/ST/STI per start
//             pulse over a req/ack data-memory bus. Indirect ops chain a
//             pointer read and a second access. A watchdog aborts accesses
//             that are never acknowledged.
//  Revision : 1.0 - initial release
// ============================================================================
module lc3_memaccess_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] memout,
  output logic [15:0] DMem_addr,
  output logic [15:0] Dmem_din,
  output logic        DMem_rd,
  output logic        DMem_req,
  input  logic        DMem_ack,
  input  logic [15:0] DMem_dout
);

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;

  // Abort fires on the last allowed request cycle if no ack arrives in it.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    PTR  = 3'd2,
    ACC2 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        rd_q, rd_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] memout_q, memout_d;
  logic        err_q, err_d;
  logic [7:0]  wd_q, wd_d;

  // Status and request strobes are decoded straight from the state register.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign DMem_req  = (state_q == ACC1) || (state_q == ACC2);
  assign DMem_addr = addr_q;
  assign Dmem_din  = din_q;
  assign DMem_rd   = rd_q;
  assign memout    = memout_q;

  // Next-state, bus-register and watchdog computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rd_d     = rd_q;
    ptr_d    = ptr_q;
    memout_d = memout_q;
    err_d    = 1'b0;
    wd_d     = wd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          addr_d  = M_Addr;
          // STI reads its pointer first, so only a plain ST writes in ACC1.
          rd_d    = (op != OP_ST);
          // Store data is captured for both store flavours; loads leave it.
          if (op[1]) din_d = M_Data;
          state_d = ACC1;
        end
      end
      ACC1: begin
        if (DMem_ack) begin
          if (op_q == OP_LD) begin
            memout_d = DMem_dout;
            state_d  = DONE;
          end else if (op_q == OP_ST) begin
            state_d  = DONE;
          end else begin
            ptr_d    = DMem_dout;
            state_d  = PTR;
          end
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      PTR: begin
        // Bus registers switch here so they are settled when req rises again.
        addr_d  = ptr_q;
        rd_d    = (op_q == OP_LDI);
        state_d = ACC2;
      end
      ACC2: begin
        if (DMem_ack) begin
          if (op_q == OP_LDI) memout_d = DMem_dout;
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      wd_d = 8'd0;
    end else if (DMem_req && !DMem_ack) begin
      wd_d = wd_q + 8'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      addr_q   <= 16'h0000;
      din_q    <= 16'h0000;
      rd_q     <= 1'b1;
      ptr_q    <= 16'h0000;
      memout_q <= 16'h0000;
      err_q    <= 1'b0;
      wd_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd_q     <= rd_d;
      ptr_q    <= ptr_d;
      memout_q <= memout_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

endmodule
`default_nettype wire
